board_io_ctrl: RTL and testbench

Board-level I/O front end that sits between the DE2 pins and the CPU `TopLevel`, replacing the direct switch-to-port wiring. It synchronises and debounces all switches and pushbuttons and derives a stretched CPU reset, the forwarding enable and a run/single-step clock enable. It also drives the seven-segment digits with a registered hex view of a debug word. All widths, the digit count and the debounce and reset-stretch intervals are parametrised.

---
 rtl/board_pkg.sv | 41 ++++
 rtl/board_io_ctrl_debounce.sv | 56 +++++
 rtl/board_io_ctrl.sv | 99 +++++++++
 tb/tb_board_io_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the DE2 board I/O front end: switch/key roles,
// run mode encoding and the seven-segment decoder.
package board_pkg;

  localparam int SW_RST   = 0;
  localparam int SW_FWD   = 1;
  localparam int SW_STEP  = 2;
  localparam int KEY_STEP = 0;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } run_mode_t;

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/board_io_ctrl_debounce.sv
// One-bit 2-FF synchroniser plus debounce counter; reports the accepted
// level and a registered one-cycle pulse on each accepted 1->0 change.
module debounce #(
  parameter int   CYCLES    = 50000,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall_pulse
);

  localparam int CNT_W = $clog2(CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      prev_q   <= RESET_VAL;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      fall_q   <= prev_q & ~stable_q;
    end
  end

  assign level      = stable_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// DE2 board I/O front end: debounced switches/keys, stretched CPU reset,
// run/single-step clock enable and registered hex display of a debug word.
module board_io_ctrl
  import board_pkg::*;
#(
  parameter int NUM_SW          = 18,
  parameter int NUM_KEY         = 4,
  parameter int NUM_HEX         = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RST_HOLD        = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_SW-1:0]    sw,
  input  logic [NUM_KEY-1:0]   key,
  input  logic [4*NUM_HEX-1:0] dbg_word,
  output logic [NUM_SW-1:0]    sw_db,
  output logic [NUM_KEY-1:0]   key_press,
  output logic                 cpu_rst,
  output logic                 forward_en,
  output logic                 cpu_clk_en,
  output logic [7*NUM_HEX-1:0] hex_out
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  logic [NUM_SW-1:0]    sw_fall_unused;
  logic [NUM_KEY-1:0]   key_level_unused;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 step_q, step_d;
  logic [7*NUM_HEX-1:0] hex_q, hex_d;
  run_mode_t            mode;

  for (genvar i = 0; i < NUM_SW; i++) begin : gen_sw
    debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_db (
      .clock      (clock),
      .rst        (rst),
      .din        (sw[i]),
      .level      (sw_db[i]),
      .fall_pulse (sw_fall_unused[i])
    );
  end

  // Keys idle high, so their synchronisers and stable values reset to 1.
  for (genvar i = 0; i < NUM_KEY; i++) begin : gen_key
    debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_db (
      .clock      (clock),
      .rst        (rst),
      .din        (key[i]),
      .level      (key_level_unused[i]),
      .fall_pulse (key_press[i])
    );
  end

  always_comb begin
    hold_d    = hold_q;
    cpu_rst_d = cpu_rst_q;
    if (sw_db[SW_RST]) begin
      hold_d    = HOLD_W'(RST_HOLD);
      cpu_rst_d = 1'b1;
    end else if (hold_q != '0) begin
      hold_d    = hold_q - HOLD_W'(1);
      cpu_rst_d = 1'b1;
    end else begin
      cpu_rst_d = 1'b0;
    end

    // A press seen while the CPU is held in reset is discarded.
    step_d = key_press[KEY_STEP] & ~cpu_rst_q;
    mode   = sw_db[SW_STEP] ? MODE_STEP : MODE_RUN;

    hex_d = '0;
    for (int i = 0; i < NUM_HEX; i++) begin
      hex_d[7*i +: 7] = seg7_decode(dbg_word[4*i +: 4]);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hold_q    <= HOLD_W'(RST_HOLD);
      cpu_rst_q <= 1'b1;
      step_q    <= 1'b0;
      hex_q     <= '1;
    end else begin
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      step_q    <= step_d;
      hex_q     <= hex_d;
    end
  end

  // Mode is muxed after the step register so a switch change acts at once.
  assign cpu_clk_en = ~cpu_rst_q & ((mode == MODE_RUN) | step_q);
  assign cpu_rst    = cpu_rst_q;
  assign forward_en = sw_db[SW_FWD];
  assign hex_out    = hex_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: expectations are queued with their
// due cycle when stimulus is applied and compared as that cycle arrives.
module tb_board_io_ctrl;

  localparam int NUM_SW  = 18;
  localparam int NUM_KEY = 4;
  localparam int NUM_HEX = 2;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NUM_SW-1:0]    sw;
  logic [NUM_KEY-1:0]   key;
  logic [4*NUM_HEX-1:0] dbg_word;
  logic [NUM_SW-1:0]    sw_db;
  logic [NUM_KEY-1:0]   key_press;
  logic                 cpu_rst;
  logic                 forward_en;
  logic                 cpu_clk_en;
  logic [7*NUM_HEX-1:0] hex_out;

  typedef enum int {S_CPU_RST, S_CLK_EN, S_FWD, S_KEYP0, S_SWDB, S_HEX} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  board_io_ctrl #(
    .NUM_SW          (NUM_SW),
    .NUM_KEY         (NUM_KEY),
    .NUM_HEX         (NUM_HEX),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD        (3)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .sw         (sw),
    .key        (key),
    .dbg_word   (dbg_word),
    .sw_db      (sw_db),
    .key_press  (key_press),
    .cpu_rst    (cpu_rst),
    .forward_en (forward_en),
    .cpu_clk_en (cpu_clk_en),
    .hex_out    (hex_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_CPU_RST: return 32'(cpu_rst);
      S_CLK_EN:  return 32'(cpu_clk_en);
      S_FWD:     return 32'(forward_en);
      S_KEYP0:   return 32'(key_press[0]);
      S_SWDB:    return 32'(sw_db);
      S_HEX:     return 32'(hex_out);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] hex_ref(input logic [7:0] w);
    return 32'({SEG_REF[w[7:4]], SEG_REF[w[3:0]]});
  endfunction

  // Sorted insert keeps the queue ordered by due cycle.
  task automatic expect_at(input int unsigned at, input sig_e s, input logic [31:0] v);
    exp_t        item;
    int          idx;
    item.cyc = at;
    item.sig = s;
    item.val = v;
    idx      = sb_q.size();
    while (idx > 0 && sb_q[idx-1].cyc > at) idx--;
    sb_q.insert(idx, item);
  endtask

  task automatic expect_span(input int unsigned from, input int unsigned to,
                             input sig_e s, input logic [31:0] v);
    for (int unsigned k = from; k <= to; k++) expect_at(k, s, v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t item;
    sig_e s;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      item = sb_q.pop_front();
      s    = item.sig;
      check(s.name(), sample(s), item.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c, f, r, a, e, p, m, n;
    logic [7:0]  words [4];
    words = '{8'hA5, 8'h3F, 8'hC7, 8'h1E};

    rst      = 1'b0;
    sw       = '0;
    key      = '1;
    dbg_word = '0;
    step(3);

    check("rst_cpu_rst",    32'(cpu_rst), 32'd1);
    check("rst_cpu_clk_en", 32'(cpu_clk_en), 32'd0);
    check("rst_sw_db",      32'(sw_db), 32'd0);
    check("rst_forward_en", 32'(forward_en), 32'd0);
    check("rst_key_press",  32'(key_press), 32'd0);
    check("rst_hex_blank",  32'(hex_out), 32'h3FFF);

    // Reset release: cpu_rst held for RST_HOLD+1 cycles, then RUN enables.
    c = cyc;
    expect_span(c + 1, c + 3, S_CPU_RST, 32'd1);
    expect_span(c + 1, c + 3, S_CLK_EN, 32'd0);
    expect_at(c + 4, S_CPU_RST, 32'd0);
    expect_span(c + 5, c + 7, S_CLK_EN, 32'd1);
    expect_at(c + 1, S_HEX, hex_ref(8'h00));
    rst = 1'b1;
    step(8);

    // A 3-cycle glitch on sw[1] must not reach forward_en.
    c = cyc;
    expect_span(c + 1, c + 10, S_FWD, 32'd0);
    sw[1] = 1'b1;
    step(3);
    sw[1] = 1'b0;
    step(9);

    // A held change appears exactly 6 cycles after the edge.
    c = cyc;
    expect_at(c + 5, S_FWD, 32'd0);
    expect_at(c + 6, S_FWD, 32'd1);
    expect_at(c + 6, S_SWDB, 32'h2);
    sw[1] = 1'b1;
    step(8);

    // STEP mode with a bouncing key: one pulse, 8 cycles after the last fall.
    c = cyc;
    f = c + 10;
    expect_at(c + 5, S_CLK_EN, 32'd1);
    expect_span(c + 6, f + 7, S_CLK_EN, 32'd0);
    expect_at(f + 8, S_CLK_EN, 32'd1);
    expect_span(f + 9, f + 14, S_CLK_EN, 32'd0);
    expect_at(c + 6, S_SWDB, 32'h6);
    expect_at(f + 6, S_KEYP0, 32'd0);
    expect_at(f + 7, S_KEYP0, 32'd1);
    expect_at(f + 8, S_KEYP0, 32'd0);
    sw[2] = 1'b1;
    step(8);
    key[0] = 1'b0;
    step(1);
    key[0] = 1'b1;
    step(1);
    key[0] = 1'b0;
    step(15);

    // Release produces neither a key_press nor an enable pulse.
    r = cyc;
    expect_span(r + 1, r + 12, S_CLK_EN, 32'd0);
    expect_span(r + 1, r + 12, S_KEYP0, 32'd0);
    key[0] = 1'b1;
    step(14);

    // Press during cpu_rst is dropped; a press after the hold gives one pulse.
    a = cyc;
    e = a + 28;
    p = e + 12;
    expect_at(a + 6, S_CPU_RST, 32'd0);
    expect_at(a + 7, S_CPU_RST, 32'd1);
    expect_at(a + 15, S_KEYP0, 32'd1);
    expect_at(e + 9, S_CPU_RST, 32'd1);
    expect_at(e + 10, S_CPU_RST, 32'd0);
    expect_span(a + 1, p + 7, S_CLK_EN, 32'd0);
    expect_at(p + 8, S_CLK_EN, 32'd1);
    expect_span(p + 9, p + 14, S_CLK_EN, 32'd0);
    sw[0] = 1'b1;
    step(8);
    key[0] = 1'b0;
    step(10);
    key[0] = 1'b1;
    step(10);
    sw[0] = 1'b0;
    step(12);
    key[0] = 1'b0;
    step(15);
    key[0] = 1'b1;
    step(14);

    // Hex view: one cycle latency; the first word uses the literal digits.
    expect_at(cyc + 1, S_HEX, 32'({7'b0001000, 7'b0010010}));
    dbg_word = words[0];
    step(1);
    for (int i = 1; i < 4; i++) begin
      expect_at(cyc + 1, S_HEX, hex_ref(words[i]));
      dbg_word = words[i];
      step(1);
    end
    step(2);

    // Reset mid-debounce clears the counter; the full 2+4 cycles are needed again.
    c = cyc;
    expect_at(c + 6, S_FWD, 32'd0);
    sw[1] = 1'b0;
    step(8);
    m = cyc;
    expect_at(m + 3, S_FWD, 32'd0);
    expect_at(m + 5, S_FWD, 32'd0);
    expect_at(m + 6, S_FWD, 32'd0);
    sw[1] = 1'b1;
    step(4);
    rst = 1'b0;
    step(2);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_hex",     32'(hex_out), 32'h3FFF);
    n = cyc;
    expect_at(n + 5, S_FWD, 32'd0);
    expect_at(n + 6, S_FWD, 32'd1);
    rst = 1'b1;
    step(10);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
